// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-port signal bundle for mem_arbiter
// ARB_STATS_EN adds the grant/conflict/stall counter outputs.
interface mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        mem_stall;
  logic [15:0] mem_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        i_done;
  logic        d_done;
  logic [15:0] rdata;
  logic        busy;
`ifdef ARB_STATS_EN
  logic [15:0] i_grant_cnt;
  logic [15:0] d_grant_cnt;
  logic [15:0] conflict_cnt;
  logic [15:0] stall_cnt;

  modport master (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_stall, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, i_done, d_done, rdata, busy,
    output i_grant_cnt, d_grant_cnt, conflict_cnt, stall_cnt
  );
  modport slave (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_stall, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, i_done, d_done, rdata, busy,
    input  i_grant_cnt, d_grant_cnt, conflict_cnt, stall_cnt
  );
`else
  modport master (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_stall, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, i_done, d_done, rdata, busy
  );
  modport slave (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_stall, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, i_done, d_done, rdata, busy
  );
`endif
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache arbiter for a single fixed-latency memory port
// Optional statistics counters are enabled with ARB_STATS_EN.
module mem_arbiter #(
  parameter int MEM_LAT  = 4,
  parameter int MAX_DWIN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);
  localparam logic [2:0] DWIN_MAX = 3'(MAX_DWIN);

  state_t      state_q;
  logic        owner_d_q;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic [3:0]  lat_q;
  logic [2:0]  starve_q;

  logic        conflict;
  logic        pick_d;
  logic [2:0]  starve_d;

  // D wins conflicts until it has taken MAX_DWIN in a row; then I is forced through.
  always_comb begin
    conflict = bus.i_req & bus.d_req;
    pick_d   = bus.d_req & ~(conflict & (starve_q == DWIN_MAX));
    starve_d = starve_q;
    if (pick_d && conflict)
      starve_d = starve_q + 3'd1;
    else if (!pick_d && bus.i_req)
      starve_d = 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_d_q <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      lat_q     <= '0;
      starve_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            owner_d_q <= pick_d;
            wr_q      <= pick_d & bus.d_wr;
            addr_q    <= pick_d ? bus.d_addr : bus.i_addr;
            wdata_q   <= pick_d ? bus.d_wdata : 16'h0000;
            starve_q  <= starve_d;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.mem_stall) begin
            lat_q   <= LAT_LOAD;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (lat_q == 4'd0) begin
            if (!wr_q)
              rdata_q <= bus.mem_rdata;
            state_q <= DONE;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_wr    = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_done    = (state_q == DONE) & ~owner_d_q;
  assign bus.d_done    = (state_q == DONE) & owner_d_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != IDLE);

`ifdef ARB_STATS_EN
  logic [15:0] i_grant_cnt_q;
  logic [15:0] d_grant_cnt_q;
  logic [15:0] conflict_cnt_q;
  logic [15:0] stall_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_grant_cnt_q  <= '0;
      d_grant_cnt_q  <= '0;
      conflict_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (state_q == IDLE && bus.d_req && pick_d)
        d_grant_cnt_q <= sat_inc(d_grant_cnt_q);
      if (state_q == IDLE && bus.i_req && !pick_d)
        i_grant_cnt_q <= sat_inc(i_grant_cnt_q);
      if (state_q == IDLE && conflict)
        conflict_cnt_q <= sat_inc(conflict_cnt_q);
      if (state_q == ISSUE && bus.mem_stall)
        stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign bus.i_grant_cnt  = i_grant_cnt_q;
  assign bus.d_grant_cnt  = d_grant_cnt_q;
  assign bus.conflict_cnt = conflict_cnt_q;
  assign bus.stall_cnt    = stall_cnt_q;
`endif
endmodule
